// File: rtl/ex_mem_pkg.sv
// Shared types for the execute-to-memory stage: payload bundle, buffer state, widths.
package ex_mem_pkg;

   localparam int EM_XLEN = 32;
   localparam int EM_RA_W = 5;

   typedef struct packed {
      logic [EM_XLEN-1:0] res;
      logic [EM_XLEN-1:0] store_data;
      logic [EM_XLEN-1:0] pc;
      logic [EM_RA_W-1:0] rd;
      logic               reg_write;
      logic               mem_read;
      logic               mem_write;
      logic               c_out;
   } ex_mem_t;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2,
      BUF_TRAP  = 2'd3
   } buf_state_t;

   // A trapping instruction must not retire any architectural side effect.
   function automatic ex_mem_t squash_ctrl(input ex_mem_t b);
      ex_mem_t r;
      r           = b;
      r.reg_write = 1'b0;
      r.mem_read  = 1'b0;
      r.mem_write = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/ex_mem_skid.sv
// Two-slot skid buffer over ex_mem_t with flush and a trap-hold that stops accepts
// after the flagged bundle is enqueued.
//
// state     | meaning
// BUF_EMPTY | no entries, accepting
// BUF_ONE   | output slot full, accepting
// BUF_TWO   | output and skid slots full, not accepting
// BUF_TRAP  | trap bundle enqueued; entries drain, no accepts until flush/rst
module ex_mem_skid
   import ex_mem_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    flush,
   input  logic    in_valid,
   input  logic    hold,
   input  ex_mem_t in_data,
   output logic    in_ready,
   output logic    out_valid,
   output ex_mem_t out_data,
   input  logic    out_ready
);

   buf_state_t state;
   ex_mem_t    skid_data;
   logic       out_full;
   logic       skid_full;
   logic       in_fire;
   logic       out_fire;

   assign in_ready  = (state == BUF_EMPTY) || (state == BUF_ONE);
   assign out_valid = out_full;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_full && out_ready;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state     <= BUF_EMPTY;
         out_full  <= 1'b0;
         skid_full <= 1'b0;
         out_data  <= '0;
         skid_data <= '0;
      end else begin
         case (state)
            BUF_EMPTY: begin
               if (in_fire) begin
                  out_data <= in_data;
                  out_full <= 1'b1;
                  state    <= hold ? BUF_TRAP : BUF_ONE;
               end
            end
            BUF_ONE: begin
               if (in_fire && out_fire) begin
                  out_data <= in_data;
                  state    <= hold ? BUF_TRAP : BUF_ONE;
               end else if (in_fire) begin
                  skid_data <= in_data;
                  skid_full <= 1'b1;
                  state     <= hold ? BUF_TRAP : BUF_TWO;
               end else if (out_fire) begin
                  out_full <= 1'b0;
                  state    <= BUF_EMPTY;
               end
            end
            BUF_TWO: begin
               if (out_fire) begin
                  out_data  <= skid_data;
                  skid_full <= 1'b0;
                  state     <= BUF_ONE;
               end
            end
            BUF_TRAP: begin
               // Held entries keep draining; only flush/rst leaves this state.
               if (out_fire) begin
                  if (skid_full) begin
                     out_data  <= skid_data;
                     skid_full <= 1'b0;
                  end else begin
                     out_full <= 1'b0;
                  end
               end
            end
            default: begin
               state    <= BUF_EMPTY;
               out_full <= 1'b0;
               skid_full <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: registers ALU results and control toward MEM through a
// skid buffer, resolves taken branches and raises the signed-overflow trap.
module ex_mem_stage
   import ex_mem_pkg::*;
#(
   parameter int XLEN = EM_XLEN,
   parameter int RA_W = EM_RA_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] alu_res,
   input  logic            alu_v,
   input  logic            alu_c_out,
   input  logic            alu_zero,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [RA_W-1:0] ex_rd,
   input  logic            ex_reg_write,
   input  logic            ex_mem_read,
   input  logic            ex_mem_write,
   input  logic [XLEN-1:0] ex_store_data,
   input  logic            ex_ovf_trap,
   input  logic            ex_branch,
   input  logic [XLEN-1:0] ex_br_target,
   output logic            mem_valid,
   input  logic            mem_ready,
   output logic [XLEN-1:0] mem_res,
   output logic [XLEN-1:0] mem_store_data,
   output logic [XLEN-1:0] mem_pc,
   output logic [RA_W-1:0] mem_rd,
   output logic            mem_reg_write,
   output logic            mem_mem_read,
   output logic            mem_mem_write,
   output logic            mem_c_out,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            exc_valid,
   output logic [XLEN-1:0] exc_pc
);

   ex_mem_t in_bundle;
   ex_mem_t enq_bundle;
   ex_mem_t out_bundle;
   logic    accept;
   logic    trap_hit;
   logic    br_taken;
   logic    fire_redirect;
   logic    fire_exc;
   logic    unused_zero;

   // The zero flag is carried for upstream debug only; branches use the compare result.
   assign unused_zero = alu_zero;

   assign accept   = in_valid && in_ready;
   assign trap_hit = ex_ovf_trap && alu_v;
   assign br_taken = ex_branch && alu_res[0];

   // Trap outranks a same-cycle taken branch; flush suppresses both pulses.
   assign fire_exc      = accept && trap_hit && !flush;
   assign fire_redirect = accept && br_taken && !trap_hit && !flush;

   always_comb begin
      in_bundle            = '0;
      in_bundle.res        = alu_res;
      in_bundle.store_data = ex_store_data;
      in_bundle.pc         = ex_pc;
      in_bundle.rd         = ex_rd;
      in_bundle.reg_write  = ex_reg_write;
      in_bundle.mem_read   = ex_mem_read;
      in_bundle.mem_write  = ex_mem_write;
      in_bundle.c_out      = alu_c_out;
      enq_bundle           = trap_hit ? squash_ctrl(in_bundle) : in_bundle;
   end

   ex_mem_skid u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .hold      (trap_hit),
      .in_data   (enq_bundle),
      .in_ready  (in_ready),
      .out_valid (mem_valid),
      .out_data  (out_bundle),
      .out_ready (mem_ready)
   );

   assign mem_res        = out_bundle.res;
   assign mem_store_data = out_bundle.store_data;
   assign mem_pc         = out_bundle.pc;
   assign mem_rd         = out_bundle.rd;
   assign mem_reg_write  = out_bundle.reg_write;
   assign mem_mem_read   = out_bundle.mem_read;
   assign mem_mem_write  = out_bundle.mem_write;
   assign mem_c_out      = out_bundle.c_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         exc_valid      <= 1'b0;
         exc_pc         <= '0;
      end else begin
         redirect_valid <= fire_redirect;
         exc_valid      <= fire_exc;
         if (fire_redirect) begin
            redirect_pc <= ex_br_target;
         end
         if (fire_exc) begin
            exc_pc <= ex_pc;
         end
      end
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: queue-based reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready;
   logic [31:0] alu_res;
   logic        alu_v, alu_c_out, alu_zero;
   logic [31:0] ex_pc;
   logic [4:0]  ex_rd;
   logic        ex_reg_write, ex_mem_read, ex_mem_write;
   logic [31:0] ex_store_data;
   logic        ex_ovf_trap, ex_branch;
   logic [31:0] ex_br_target;
   logic        mem_valid, mem_ready;
   logic [31:0] mem_res, mem_store_data, mem_pc;
   logic [4:0]  mem_rd;
   logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_c_out;
   logic        redirect_valid, exc_valid;
   logic [31:0] redirect_pc, exc_pc;

   always #5 clk = ~clk;

   ex_mem_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .alu_res(alu_res), .alu_v(alu_v), .alu_c_out(alu_c_out), .alu_zero(alu_zero),
      .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_store_data(ex_store_data), .ex_ovf_trap(ex_ovf_trap), .ex_branch(ex_branch),
      .ex_br_target(ex_br_target), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_res(mem_res), .mem_store_data(mem_store_data), .mem_pc(mem_pc),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
      .mem_mem_write(mem_mem_write), .mem_c_out(mem_c_out),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .exc_valid(exc_valid), .exc_pc(exc_pc)
   );

   typedef struct {
      logic [31:0] res, sd, pc;
      logic [4:0]  rd;
      logic        rw, mr, mw, c;
   } mdl_t;

   mdl_t        exp_q[$];
   logic        m_trap = 1'b0, m_redir = 1'b0, m_exc = 1'b0, last_acc = 1'b0;
   logic [31:0] m_redir_pc = '0, m_exc_pc = '0;
   int          checks = 0, errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic compare();
      chk("mem_valid", mem_valid, exp_q.size() > 0);
      chk("in_ready", in_ready, !m_trap && exp_q.size() < 2);
      chk("redirect_valid", redirect_valid, m_redir);
      chk("exc_valid", exc_valid, m_exc);
      if (m_redir) chk("redirect_pc", redirect_pc, m_redir_pc);
      if (m_exc) chk("exc_pc", exc_pc, m_exc_pc);
      if (exp_q.size() > 0) begin
         chk("mem_res", mem_res, exp_q[0].res);
         chk("mem_store_data", mem_store_data, exp_q[0].sd);
         chk("mem_pc", mem_pc, exp_q[0].pc);
         chk("mem_rd", mem_rd, exp_q[0].rd);
         chk("mem_reg_write", mem_reg_write, exp_q[0].rw);
         chk("mem_mem_read", mem_mem_read, exp_q[0].mr);
         chk("mem_mem_write", mem_mem_write, exp_q[0].mw);
         chk("mem_c_out", mem_c_out, exp_q[0].c);
      end
   endtask

   // Advance one clock: update the model from the inputs presented this cycle, then check.
   task automatic cycle();
      logic acc, trap_hit, taken;
      mdl_t b;
      acc      = in_valid && !m_trap && exp_q.size() < 2;
      trap_hit = ex_ovf_trap && alu_v;
      taken    = ex_branch && alu_res[0];
      b.res = alu_res; b.sd = ex_store_data; b.pc = ex_pc; b.rd = ex_rd;
      b.rw  = ex_reg_write && !trap_hit;
      b.mr  = ex_mem_read && !trap_hit;
      b.mw  = ex_mem_write && !trap_hit;
      b.c   = alu_c_out;
      @(posedge clk);
      if (rst || flush) begin
         exp_q.delete();
         m_trap = 1'b0; m_redir = 1'b0; m_exc = 1'b0; last_acc = 1'b0;
      end else begin
         if (exp_q.size() > 0 && mem_ready) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(b);
         if (acc && trap_hit) m_trap = 1'b1;
         m_redir = acc && taken && !trap_hit;
         m_exc   = acc && trap_hit;
         if (m_redir) m_redir_pc = ex_br_target;
         if (m_exc) m_exc_pc = ex_pc;
         last_acc = acc;
      end
      #1;
      compare();
   endtask

   task automatic set_b(input logic [31:0] res, input logic [31:0] pc, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw, input logic c);
      alu_res = res; ex_pc = pc; ex_rd = rd; ex_reg_write = rw; ex_mem_read = mr;
      ex_mem_write = mw; alu_c_out = c; ex_store_data = ~res ^ pc;
      alu_v = 1'b0; ex_ovf_trap = 1'b0; ex_branch = 1'b0; ex_br_target = pc + 32'h40;
   endtask

   task automatic offer(input int max_cycles);
      in_valid = 1'b1;
      for (int k = 0; k < max_cycles; k++) begin
         cycle();
         if (last_acc) break;
      end
      chk("offer_accepted", last_acc, 1'b1);
      in_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; mem_ready = 1'b1; alu_zero = 1'b0;
      set_b(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(); cycle();
      chk("reset_mem_valid", mem_valid, 1'b0);
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_mem_res", mem_res, 32'h0);
      chk("reset_redirect_pc", redirect_pc, 32'h0);
      rst = 1'b0;
      cycle();

      // Back-to-back stream with no backpressure
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_b(32'h100 + i, 32'h1000 + 4 * i, 5'(i + 1), i[0], i[1], i[2], i[0]);
         cycle();
         if (i == 0) chk("stream_first_res", mem_res, 32'h100);
         chk("stream_in_ready", in_ready, 1'b1);
      end
      chk("stream_last_pc", mem_pc, 32'h101C);
      in_valid = 1'b0;
      cycle();

      // Backpressure: third bundle stalls until mem_ready returns
      mem_ready = 1'b0;
      set_b(32'h200, 32'h2000, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1); offer(4);
      set_b(32'h201, 32'h2004, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0); offer(4);
      chk("bp_in_ready_low", in_ready, 1'b0);
      set_b(32'h202, 32'h2008, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
      in_valid = 1'b1;
      cycle(); cycle();
      chk("bp_held_res", mem_res, 32'h200);
      mem_ready = 1'b1;
      offer(6);
      for (int i = 0; i < 3; i++) cycle();

      // Taken and not-taken branches
      set_b(32'h1, 32'h0040_00F0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
      ex_branch = 1'b1; ex_br_target = 32'h0040_0100;
      offer(4);
      chk("br_redirect_valid", redirect_valid, 1'b1);
      chk("br_redirect_pc", redirect_pc, 32'h0040_0100);
      cycle();
      chk("br_pulse_one_cycle", redirect_valid, 1'b0);
      set_b(32'h2, 32'h0040_00F4, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      ex_branch = 1'b1; alu_zero = 1'b1;
      offer(4);
      chk("br_not_taken", redirect_valid, 1'b0);
      alu_zero = 1'b0;
      cycle();

      // Overflow trap with a simultaneous taken branch
      mem_ready = 1'b0;
      set_b(32'h1, 32'h0040_0020, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
      ex_ovf_trap = 1'b1; alu_v = 1'b1; ex_branch = 1'b1;
      offer(4);
      chk("trap_reg_write", mem_reg_write, 1'b0);
      chk("trap_exc_valid", exc_valid, 1'b1);
      chk("trap_exc_pc", exc_pc, 32'h0040_0020);
      chk("trap_no_redirect", redirect_valid, 1'b0);
      chk("trap_in_ready", in_ready, 1'b0);
      set_b(32'h300, 32'h3000, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1;
      cycle();
      mem_ready = 1'b1;
      cycle(); cycle(); cycle();
      chk("trap_still_blocked", in_ready, 1'b0);
      flush = 1'b1;
      cycle();
      flush = 1'b0; in_valid = 1'b0;
      chk("trap_flush_ready", in_ready, 1'b1);
      cycle();

      // Flush while two entries are held and a taken branch is offered
      mem_ready = 1'b0;
      set_b(32'h400, 32'h4000, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0); offer(4);
      set_b(32'h401, 32'h4004, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0); offer(4);
      set_b(32'h1, 32'h4008, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
      ex_branch = 1'b1;
      in_valid = 1'b1; flush = 1'b1;
      cycle();
      flush = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
      chk("flush_mem_valid", mem_valid, 1'b0);
      chk("flush_in_ready", in_ready, 1'b1);
      chk("flush_no_redirect", redirect_valid, 1'b0);
      for (int i = 0; i < 3; i++) cycle();

      // Reset mid-stream with both slots full
      mem_ready = 1'b0;
      set_b(32'h500, 32'h5000, 5'd13, 1'b1, 1'b1, 1'b1, 1'b1); offer(4);
      set_b(32'h501, 32'h5004, 5'd14, 1'b1, 1'b1, 1'b1, 1'b1); offer(4);
      rst = 1'b1;
      cycle();
      chk("rst_mem_valid", mem_valid, 1'b0);
      chk("rst_mem_pc", mem_pc, 32'h0);
      chk("rst_mem_rd", mem_rd, 5'd0);
      chk("rst_in_ready", in_ready, 1'b1);
      rst = 1'b0; mem_ready = 1'b1;
      cycle();

      // Mixed traffic with irregular valid/ready patterns
      for (int i = 0; i < 32; i++) begin
         logic [31:0] rdy_pat, vld_pat;
         rdy_pat = 32'hB6D3_5A9C;
         vld_pat = 32'hDB7E_6F3B;
         set_b($urandom, $urandom, 5'($urandom_range(0, 31)), i[0], i[1], i[2], i[3]);
         ex_branch = i[2];
         mem_ready = rdy_pat[i];
         in_valid  = vld_pat[i];
         cycle();
      end
      in_valid = 1'b0; mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline stage that consumes the ALU outputs (`res`, `v`, `c_out`, `zero`) together with the EX control bundle and registers them toward the MEM stage. A valid/ready handshake with a two-slot skid buffer decouples the stage from memory stalls. The stage resolves branches from the ALU compare result and raises the signed-overflow trap for trapping add/sub. It sits directly downstream of the ALU, inside the execute unit.

## Interface
- `XLEN`, 32, datapath width
- `RA_W`, 5, register-address width
- `clk` in 1, rising-edge clock
- `rst` in 1, synchronous, active-high reset
- `flush` in 1, synchronous squash from the hazard/exception unit
- `in_valid` in 1, EX bundle valid
- `in_ready` out 1, stage can accept
- `alu_res` in XLEN, ALU result
- `alu_v` in 1, ALU signed overflow
- `alu_c_out` in 1, ALU carry
- `alu_zero` in 1, ALU zero flag
- `ex_pc` in XLEN, instruction PC
- `ex_rd` in RA_W, destination register
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write` in 1 each, control bits
- `ex_store_data` in XLEN, store operand
- `ex_ovf_trap` in 1, instruction traps on overflow (ADD/SUB/ADDI)
- `ex_branch` in 1, instruction is a conditional branch
- `ex_br_target` in XLEN, precomputed branch target
- `mem_valid` out 1, `mem_ready` in 1, downstream handshake
- `mem_res`, `mem_store_data`, `mem_pc` out XLEN; `mem_rd` out RA_W
- `mem_reg_write`, `mem_mem_read`, `mem_mem_write`, `mem_c_out` out 1
- `redirect_valid` out 1, `redirect_pc` out XLEN, one-cycle taken-branch pulse
- `exc_valid` out 1, `exc_pc` out XLEN, one-cycle overflow-trap pulse

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `mem_valid && mem_ready`.
- Buffer states:
  - EMPTY: `mem_valid`=0, `in_ready`=1.
  - ONE: output slot full, `in_ready`=1.
  - TWO: output and skid slots full, `in_ready`=0.
  - TRAP: `in_ready`=0, `mem_valid` still shows the held entries, no further accepts.
- Transitions:
  - in only: EMPTY→ONE, ONE→TWO.
  - out only: TWO→ONE (skid moves to output), ONE→EMPTY.
  - in and out together in ONE: stay in ONE; the new bundle goes straight to the output slot.
- Branch: taken when `ex_branch && alu_res[0]`. The ALU compare ops return 1 on true. Evaluated at transfer in. The branch itself still flows to MEM with `reg_write`/`mem_write` as supplied. There is a delay slot, so the stage never squashes the following instruction.
- Overflow trap: when `ex_ovf_trap && alu_v` at transfer in:
  - The bundle is enqueued with `reg_write`, `mem_read` and `mem_write` forced to 0.
  - `exc_pc`=`ex_pc`.
  - State enters TRAP after the enqueue.
- Trap and taken branch together: the exception wins and there is no redirect.
- `flush` has priority over everything:
  - Both slots cleared; state goes to EMPTY.
  - A same-cycle input is dropped.
  - Same-cycle redirect/exc pulses are suppressed.
  - Only `flush` or `rst` leaves TRAP.
- `alu_zero` is used only by upstream debug; it is not used for branch decisions.

## Timing
- Reset values:
  - `mem_valid`, `redirect_valid`, `exc_valid` = 0.
  - All payload outputs = 0.
  - State = EMPTY.
  - `in_ready`=1, decoded from registered state only. Upstream holds `in_valid` low during `rst`.
- Latency: transfer in at cycle N gives `mem_valid`=1 at N+1 when the stage was EMPTY, or when in ONE with an output transfer at N.
- `redirect_valid`/`redirect_pc` and `exc_valid`/`exc_pc` are registered. Each asserts at N+1 for exactly one cycle.
- `in_ready` has no combinational path from `mem_ready`. Throughput is one bundle per cycle while `mem_ready`=1.
- Held output payload is stable while `mem_valid && !mem_ready`.
- `rst` mid-stream discards all entries. No pulses fire in the cycle after reset.

## Structure
- Shared package `ex_mem_pkg` holds:
  - `ex_mem_t`, the payload struct: res, store_data, pc, rd, reg_write, mem_read, mem_write, c_out.
  - The buffer-state enum (EMPTY/ONE/TWO/TRAP).
  - XLEN/RA_W defaults.
- Sub-module `ex_mem_skid`: generic two-slot skid buffer over `ex_mem_t`, with flush and a hold input for TRAP.
- The top level owns branch/trap resolution and the pulse registers.

## Test plan
- Back-to-back stream: 8 bundles with `mem_ready`=1 → 8 outputs on consecutive cycles, one-cycle latency, order preserved, `in_ready` stays 1.
- Backpressure: `mem_ready`=0 while 3 bundles are offered → the first two are held, `in_ready`=0 after the second, the third is stalled. Releasing `mem_ready` drains them in order with no loss or duplication.
- Branch: `ex_branch`=1, `alu_res`=1, target 0x0040_0100 → `redirect_valid` one cycle later with `redirect_pc`=0x0040_0100. With `alu_res`=0 there is no pulse.
- Overflow: `ex_ovf_trap`=1, `alu_v`=1, `ex_pc`=0x0040_0020, `ex_reg_write`=1 → output has `mem_reg_write`=0, `exc_valid` pulses with `exc_pc`=0x0040_0020, and `in_ready`=0 until `flush`. A simultaneous taken branch gives no redirect.
- Flush with TWO full and `in_valid`=1 → next cycle `mem_valid`=0, state EMPTY, the dropped input never appears, no pulses.
- `rst` asserted while TWO full → all outputs return to reset values the next cycle, and `in_ready`=1.
